// File: rtl/custom_mac_lane_array_pkg.sv
// Shared constants and FSM encoding for the MAC lane array and its loader.
package custom_mac_lane_array_pkg;
    localparam int DATA_W    = 8;
    localparam int LANES     = 4;
    localparam int ACC_W     = 21;
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    // Number of load stages per pass; the loader uses the same constant.
    localparam int STAGE_CNT = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/custom_mac_lane_array_if.sv
// Loader-side controls and result drain port of the MAC lane array.
interface custom_mac_lane_array_if;
    import custom_mac_lane_array_pkg::*;

    logic [DATA_W-1:0] data_i;
    logic [LANES-1:0]  feature_en_i;
    logic [LANES-1:0]  weight_en_i;
    logic [LANES-1:0]  acc_en_i;
    logic              load_done_i;
    logic              busy_o;
    logic              res_valid_o;
    logic [ACC_W-1:0]  res_data_o;
    logic [LANE_W-1:0] res_lane_o;
    logic              res_ready_i;
    logic              drain_done_o;

    modport slave (
        input  data_i, feature_en_i, weight_en_i, acc_en_i, load_done_i, res_ready_i,
        output busy_o, res_valid_o, res_data_o, res_lane_o, drain_done_o
    );

    modport master (
        output data_i, feature_en_i, weight_en_i, acc_en_i, load_done_i, res_ready_i,
        input  busy_o, res_valid_o, res_data_o, res_lane_o, drain_done_o
    );
endinterface

// File: rtl/custom_mac_lane_array_lane.sv
// One MAC lane: feature/weight operand registers and a wrapping accumulator.
module custom_mac_lane
    import custom_mac_lane_array_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              feat_we_i,
    input  logic              wt_we_i,
    input  logic              acc_en_i,
    input  logic              clr_i,
    output logic [ACC_W-1:0]  acc_o
);
    logic [DATA_W-1:0]   feat_q, wt_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [2*DATA_W-1:0] prod;

    // Product uses the pre-write operands, so a same-cycle write does not leak in.
    always_comb begin
        prod  = feat_q * wt_q;
        acc_d = acc_q + ACC_W'(prod);
    end

    // Operand capture, accumulate, and end-of-drain clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            feat_q <= '0;
            wt_q   <= '0;
            acc_q  <= '0;
        end else if (clr_i) begin
            feat_q <= '0;
            wt_q   <= '0;
            acc_q  <= '0;
        end else begin
            if (feat_we_i) feat_q <= data_i;
            if (wt_we_i)   wt_q   <= data_i;
            if (acc_en_i)  acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/custom_mac_lane_array.sv
// MAC lane array: per-lane capture/accumulate, then serial drain of all accumulators.
module custom_mac_lane_array
    import custom_mac_lane_array_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    custom_mac_lane_array_if.slave bus
);
    state_e                       state_q;
    logic [LANE_W-1:0]            k_q;
    logic                         done_q;
    logic [LANES-1:0][ACC_W-1:0]  acc;
    logic                         cap_en, beat, last;

    // Lane controls still apply in WAIT: the final stage lags load_done by one cycle.
    assign cap_en = (state_q != ST_DRAIN);
    assign beat   = (state_q == ST_DRAIN) && bus.res_ready_i;
    assign last   = beat && (k_q == LANE_W'(LANES - 1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        custom_mac_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .data_i    (bus.data_i),
            .feat_we_i (cap_en & bus.feature_en_i[g]),
            .wt_we_i   (cap_en & bus.weight_en_i[g]),
            .acc_en_i  (cap_en & bus.acc_en_i[g]),
            .clr_i     (last),
            .acc_o     (acc[g])
        );
    end

    // Sequencer: IDLE -> WAIT (alignment) -> DRAIN over LANES beats -> IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE:  if (bus.load_done_i) state_q <= ST_WAIT;
                ST_WAIT: begin
                    state_q <= ST_DRAIN;
                    k_q     <= '0;
                end
                ST_DRAIN: if (beat) begin
                    if (last) begin
                        state_q <= ST_IDLE;
                        k_q     <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        k_q <= k_q + LANE_W'(1);
                    end
                end
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.res_valid_o  = (state_q == ST_DRAIN);
    assign bus.res_lane_o   = k_q;
    assign bus.res_data_o   = bus.res_valid_o ? acc[k_q] : '0;
    assign bus.drain_done_o = done_q;
endmodule

// File: tb/tb_custom_mac_lane_array.sv
// Randomized and directed checks of the MAC lane array against a behavioural model.
module tb_custom_mac_lane_array;
    import custom_mac_lane_array_pkg::*;

    localparam int unsigned MASK = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    custom_mac_lane_array_if bus();
    custom_mac_lane_array dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_chk  = 0;
    int n_fail = 0;

    // Model: lane operands and accumulators as plain integers.
    int unsigned feat_m[LANES], wt_m[LANES], acc_m[LANES];

    task automatic clear_model();
        for (int i = 0; i < LANES; i++) begin
            feat_m[i] = 0; wt_m[i] = 0; acc_m[i] = 0;
        end
    endtask

    task automatic idle_inputs();
        bus.data_i = '0; bus.feature_en_i = '0; bus.weight_en_i = '0;
        bus.acc_en_i = '0; bus.load_done_i = 1'b0; bus.res_ready_i = 1'b0;
    endtask

    // One loader cycle while the array accepts controls (IDLE or WAIT).
    task automatic step(input logic [7:0] d, input logic [3:0] fe, input logic [3:0] we,
                        input logic [3:0] ae, input logic ld);
        int unsigned nacc[LANES];
        bus.data_i = d; bus.feature_en_i = fe; bus.weight_en_i = we;
        bus.acc_en_i = ae; bus.load_done_i = ld;
        @(posedge clk); #1;
        for (int i = 0; i < LANES; i++)
            nacc[i] = ae[i] ? ((acc_m[i] + feat_m[i] * wt_m[i]) & MASK) : acc_m[i];
        for (int i = 0; i < LANES; i++) begin
            acc_m[i] = nacc[i];
            if (fe[i]) feat_m[i] = d;
            if (we[i]) wt_m[i] = d;
        end
        idle_inputs();
    endtask

    // load_done in IDLE, then the WAIT cycle carrying the last stage's acc enables.
    task automatic start_drain(input logic [3:0] ae_wait);
        step(8'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        n_chk++;
        if (bus.busy_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_state: busy=%0b valid=%0b, expected busy=1 valid=0",
                     bus.busy_o, bus.res_valid_o);
        end
        step(8'd0, 4'd0, 4'd0, ae_wait, 1'b0);
    endtask

    // Drain all lanes, optionally stalling one beat and driving ignored controls.
    task automatic do_drain(input int unsigned exp[LANES], input int stall_beat,
                            input int stall_cyc, input bit junk);
        for (int k = 0; k < LANES; k++) begin
            int ns;
            ns = (k == stall_beat) ? stall_cyc : 0;
            for (int s = 0; s <= ns; s++) begin
                n_chk++;
                if (bus.res_valid_o !== 1'b1 || bus.busy_o !== 1'b1 ||
                    bus.res_lane_o !== LANE_W'(k) || bus.res_data_o !== ACC_W'(exp[k])) begin
                    n_fail++;
                    $display("FAIL beat%0d: valid=%0b busy=%0b lane=%0d data=%0d, expected valid=1 busy=1 lane=%0d data=%0d",
                             k, bus.res_valid_o, bus.busy_o, bus.res_lane_o, bus.res_data_o,
                             k, exp[k] & MASK);
                end
                n_chk++;
                if (bus.drain_done_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_done: drain_done=%0b, expected 0", bus.drain_done_o);
                end
                bus.res_ready_i = (s == ns);
                if (junk) begin
                    bus.data_i = 8'($urandom); bus.feature_en_i = 4'b0001;
                    bus.weight_en_i = 4'b0010; bus.acc_en_i = 4'hF; bus.load_done_i = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        idle_inputs();
        n_chk++;
        if (bus.drain_done_o !== 1'b1 || bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%0b valid=%0b busy=%0b, expected 1 0 0",
                     bus.drain_done_o, bus.res_valid_o, bus.busy_o);
        end
        @(posedge clk); #1;
        n_chk++;
        if (bus.drain_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: drain_done=%0b, expected 0", bus.drain_done_o);
        end
        clear_model();
    endtask

    task automatic test_reset();
        int unsigned z[LANES];
        z = '{0, 0, 0, 0};
        #3;
        n_chk++;
        if (bus.busy_o !== 0 || bus.res_valid_o !== 0 || bus.res_data_o !== 0 ||
            bus.res_lane_o !== 0 || bus.drain_done_o !== 0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%0b valid=%0b data=%0d lane=%0d done=%0b, expected all 0",
                     bus.busy_o, bus.res_valid_o, bus.res_data_o, bus.res_lane_o, bus.drain_done_o);
        end
        #9 rst = 1'b1;
        @(posedge clk); #1;
        step(8'd7, 4'b0001, 4'b0001, 4'd0, 1'b0);
        step(8'd0, 4'd0, 4'd0, 4'b0001, 1'b0);
        start_drain(4'd0);
        n_chk++;
        if (bus.res_valid_o !== 1'b1 || bus.res_data_o !== ACC_W'(49)) begin
            n_fail++;
            $display("FAIL pre_reset_drain: valid=%0b data=%0d, expected valid=1 data=49",
                     bus.res_valid_o, bus.res_data_o);
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (bus.busy_o !== 0 || bus.res_valid_o !== 0 || bus.res_data_o !== 0 ||
            bus.res_lane_o !== 0 || bus.drain_done_o !== 0) begin
            n_fail++;
            $display("FAIL mid_drain_reset: busy=%0b valid=%0b data=%0d lane=%0d done=%0b, expected all 0",
                     bus.busy_o, bus.res_valid_o, bus.res_data_o, bus.res_lane_o, bus.drain_done_o);
        end
        #2 rst = 1'b1;
        clear_model();
        @(posedge clk); #1;
        n_chk++;
        if (bus.busy_o !== 0 || bus.res_valid_o !== 0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%0b valid=%0b, expected 0 0",
                     bus.busy_o, bus.res_valid_o);
        end
        start_drain(4'd0);
        do_drain(z, -1, 0, 0);
    endtask

    task automatic test_single_lane();
        int unsigned e[LANES];
        e = '{45, 0, 0, 0};
        step(8'd3, 4'b0001, 4'd0, 4'd0, 1'b0);
        step(8'd5, 4'd0, 4'b0001, 4'd0, 1'b0);
        repeat (3) step(8'd0, 4'd0, 4'd0, 4'b0001, 1'b0);
        start_drain(4'd0);
        do_drain(e, -1, 0, 0);
    endtask

    task automatic test_full_stream();
        int unsigned e[LANES];
        e = '{1755675, 1755675, 1755675, 1755675};
        for (int i = 0; i < LANES; i++) step(8'd255, 4'(1 << i), 4'(1 << i), 4'd0, 1'b0);
        for (int s = 0; s < STAGE_CNT; s++) step(8'd0, 4'd0, 4'd0, 4'hF, s == STAGE_CNT - 2);
        do_drain(e, -1, 0, 0);
    endtask

    task automatic test_hazard();
        int unsigned e[LANES];
        e = '{44, 0, 0, 0};
        step(8'd2, 4'b0001, 4'd0, 4'd0, 1'b0);
        step(8'd4, 4'd0, 4'b0001, 4'd0, 1'b0);
        step(8'd9, 4'b0001, 4'd0, 4'b0001, 1'b0);
        step(8'd0, 4'd0, 4'd0, 4'b0001, 1'b0);
        start_drain(4'd0);
        do_drain(e, -1, 0, 0);
    endtask

    task automatic test_backpressure();
        int unsigned e[LANES];
        e = '{6, 20, 42, 72};
        for (int i = 0; i < LANES; i++) begin
            step(8'(2 * i + 2), 4'(1 << i), 4'd0, 4'd0, 1'b0);
            step(8'(2 * i + 3), 4'd0, 4'(1 << i), 4'd0, 1'b0);
        end
        step(8'd0, 4'd0, 4'd0, 4'hF, 1'b0);
        start_drain(4'd0);
        do_drain(e, 1, 5, 0);
    endtask

    task automatic test_late_control();
        int unsigned e[LANES];
        e = '{21, 0, 0, 0};
        step(8'd3, 4'b0001, 4'd0, 4'd0, 1'b0);
        step(8'd7, 4'd0, 4'b0001, 4'd0, 1'b0);
        start_drain(4'b0001);
        do_drain(e, 2, 2, 1);
        for (int c = 0; c < 4; c++) begin
            n_chk++;
            if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL no_rearm c%0d: valid=%0b busy=%0b, expected 0 0",
                         c, bus.res_valid_o, bus.busy_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n, r;
            n = $urandom_range(6, 30);
            for (int s = 0; s < n; s++) begin
                logic [3:0] fe, we;
                r  = $urandom_range(0, 4);
                fe = (r == 4) ? 4'd0 : 4'(1 << r);
                r  = $urandom_range(0, 4);
                we = (r == 4) ? 4'd0 : 4'(1 << r);
                step(8'($urandom), fe, we, 4'($urandom), s == n - 2);
            end
            do_drain(acc_m, $urandom_range(0, LANES - 1), $urandom_range(0, 3), 1);
        end
    endtask

    initial begin
        idle_inputs();
        clear_model();
        test_reset();
        test_single_lane();
        test_full_stream();
        test_hazard();
        test_backpressure();
        test_late_control();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
